// File: rtl/ttl_addressable_latch_if.sv
// -----------------------------------------------------------------------------
// ttl_addressable_latch_if
//
// Purpose : Bundles the per-channel control, address, data and output signals
//           of ttl_addressable_latch so the board model can pass one handle
//           around instead of a fistful of vectors.
//
// Parameters
//   ADDR_WIDTH : address bits per channel (1..6); OUTS = 2**ADDR_WIDTH
//   CHANNELS   : number of independent channels
//
// Signals
//   nG   [CHANNELS]            active-low enable, one per channel
//   nCLR [CHANNELS]            active-low clear / mode select, one per channel
//   D    [CHANNELS]            data bit, one per channel
//   A    [CHANNELS*ADDR_WIDTH] channel c address = A[c*ADDR_WIDTH +: ADDR_WIDTH]
//   Q    [CHANNELS*OUTS]       latched outputs, channel c = Q[c*OUTS +: OUTS]
//   CHG  [CHANNELS]            one-cycle change strobe (ADDR_LATCH_CHANGE_EN only)
//
// Modports
//   master : drives nG/nCLR/D/A, observes Q (and CHG)
//   slave  : the latch itself; observes nG/nCLR/D/A, drives Q (and CHG)
//
// Configuration macro: ADDR_LATCH_CHANGE_EN adds the CHG signal.
// -----------------------------------------------------------------------------
interface ttl_addressable_latch_if #(
   parameter int ADDR_WIDTH = 3,
   parameter int CHANNELS   = 1
);

   localparam int OUTS = 1 << ADDR_WIDTH;

   logic [CHANNELS-1:0]            nG;
   logic [CHANNELS-1:0]            nCLR;
   logic [CHANNELS-1:0]            D;
   logic [CHANNELS*ADDR_WIDTH-1:0] A;
   logic [CHANNELS*OUTS-1:0]       Q;

`ifdef ADDR_LATCH_CHANGE_EN
   logic [CHANNELS-1:0]            CHG;

   modport master (
      output nG, nCLR, D, A,
      input  Q, CHG
   );

   modport slave (
      input  nG, nCLR, D, A,
      output Q, CHG
   );
`else
   modport master (
      output nG, nCLR, D, A,
      input  Q
   );

   modport slave (
      input  nG, nCLR, D, A,
      output Q
   );
`endif

endinterface : ttl_addressable_latch_if

// File: rtl/ttl_addressable_latch.sv
// -----------------------------------------------------------------------------
// ttl_addressable_latch
//
// Purpose : Clocked, parametrised 74LS259-style addressable latch. Each channel
//           decodes its address onto OUTS = 2**ADDR_WIDTH outputs and applies
//           one of four storage modes selected by {nCLR, nG}:
//             nCLR nG
//               1   0  ADDRESSABLE LATCH : Q[A] <= D, other bits hold
//               1   1  MEMORY            : all bits hold
//               0   0  DEMUX             : Q[A] <= D, other bits <= 0
//               0   1  CLEAR             : all bits <= 0
//           Channels are fully independent; outputs are registered, one clock
//           of latency, no combinational path from inputs to Q.
//
// Parameters
//   ADDR_WIDTH : address bits per channel, legal range 1..6
//   CHANNELS   : number of independent channels
//
// Ports
//   clk : system clock, all state changes on its rising edge
//   rst : synchronous active-high reset, clears Q (and CHG), overrides modes
//   bus : ttl_addressable_latch_if.slave (nG, nCLR, D, A in; Q, CHG out)
//
// Configuration macro: ADDR_LATCH_CHANGE_EN
//   Defined   : CHG[c] pulses for exactly the cycle in which channel c's Q
//               differs from its value in the previous cycle. Never raised by
//               the reset edge.
//   Undefined : CHG and its register are absent; Q behaviour is identical.
// -----------------------------------------------------------------------------
module ttl_addressable_latch #(
   parameter int ADDR_WIDTH = 3,
   parameter int CHANNELS   = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   ttl_addressable_latch_if.slave  bus
);

   localparam int OUTS = 1 << ADDR_WIDTH;

   // Encoding is literally {nCLR, nG}, so the mode is a cast of the two pins.
   typedef enum logic [1:0] {
      MODE_DEMUX  = 2'b00,
      MODE_CLEAR  = 2'b01,
      MODE_LATCH  = 2'b10,
      MODE_MEMORY = 2'b11
   } latchModeT;

   logic [CHANNELS-1:0][OUTS-1:0]       qReg;
   logic [CHANNELS-1:0][OUTS-1:0]       qNext;
   logic [CHANNELS-1:0][ADDR_WIDTH-1:0] chAddr;
   latchModeT                           chMode [CHANNELS];

   // The flat address bus already has channel c in bits [c*ADDR_WIDTH +:
   // ADDR_WIDTH], which is exactly the packed layout of chAddr.
   assign chAddr = bus.A;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_mode
      assign chMode[c] = latchModeT'({bus.nCLR[c], bus.nG[c]});
   end

   // Next-state decode. Every address value selects a real output, so the
   // indexed write never falls outside the channel.
   // NOTE: qNext gets a full default before the case so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      qNext = qReg;
      for (int c = 0; c < CHANNELS; c++) begin
         unique case (chMode[c])
            MODE_LATCH: begin
               qNext[c][chAddr[c]] = bus.D[c];
            end
            MODE_MEMORY: begin
               qNext[c] = qReg[c];
            end
            MODE_DEMUX: begin
               qNext[c]            = '0;
               qNext[c][chAddr[c]] = bus.D[c];
            end
            MODE_CLEAR: begin
               qNext[c] = '0;
            end
            default: begin
               qNext[c] = qReg[c];
            end
         endcase
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         qReg <= '0;
      end else begin
         qReg <= qNext;
      end
   end

   assign bus.Q = qReg;

`ifdef ADDR_LATCH_CHANGE_EN
   // The strobe is registered on the same edge as Q, so it is high exactly
   // while the new Q value is visible. Comparing qNext with qReg means a
   // rewrite of an already-stored value (or a clear of a zero channel) does
   // not pulse.
   logic [CHANNELS-1:0] chgReg;

   always_ff @(posedge clk) begin
      if (rst) begin
         chgReg <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            chgReg[c] <= (qNext[c] != qReg[c]);
         end
      end
   end

   assign bus.CHG = chgReg;
`endif

endmodule : ttl_addressable_latch
